// File: rtl/pos_pkg.sv
// Shared types and constants for the PoS truth-table scanner.
// map_vec turns a scan index into the {x,y,w,z} drive for either scan width.
package pos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NVEC3 = 8;
  localparam int NVEC4 = 16;
  localparam int TT_W  = 16;
  localparam int CNT_W = 5;
  localparam int IDX_W = 4;
  localparam int SET_W = 4;

  // 3-variable scans keep w at 0 and pack {x,y,z} into the low three index bits.
  function automatic logic [3:0] map_vec(input logic [IDX_W-1:0] idx, input logic mode3);
    return mode3 ? {idx[2], idx[1], 1'b0, idx[0]} : idx;
  endfunction

endpackage

// File: rtl/pos_vec_gen.sv
// Scan index counter plus registered x/y/w/z drive derived from the index.
// The scan mode is latched on load so a mid-scan change of mode3 has no effect.
module pos_vec_gen
  import pos_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mode3,
  input  logic             step,
  input  logic             park,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             x,
  output logic             y,
  output logic             w,
  output logic             z
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode3_q, mode3_d;
  logic [3:0]       vec_q, vec_d;

  assign last = (idx_q == (mode3_q ? IDX_W'(NVEC3 - 1) : IDX_W'(NVEC4 - 1)));

  always_comb begin
    idx_d   = idx_q;
    mode3_d = mode3_q;
    vec_d   = vec_q;
    if (load) begin
      idx_d   = '0;
      mode3_d = mode3;
      vec_d   = map_vec('0, mode3);
    end else if (step && !last) begin
      idx_d = idx_q + IDX_W'(1);
      vec_d = map_vec(idx_q + IDX_W'(1), mode3_q);
    end else if (park) begin
      vec_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      mode3_q <= 1'b0;
      vec_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      mode3_q <= mode3_d;
      vec_q   <= vec_d;
    end
  end

  assign idx = idx_q;
  assign {x, y, w, z} = vec_q;

endmodule

// File: rtl/pos_table_scanner.sv
// Clocked scanner that walks the PoS block through every input vector and
// captures a truth table and maxterm count per output, readable by index.
module pos_table_scanner
  import pos_pkg::*;
#(
  parameter int NOUT   = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode3,
  output logic             x,
  output logic             y,
  output logic             w,
  output logic             z,
  input  logic [NOUT-1:0]  s,
  output logic             busy,
  output logic             done,
  input  logic [2:0]       rd_sel,
  output logic [TT_W-1:0]  rd_table,
  output logic [CNT_W-1:0] rd_zeros
);

  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

  state_t                         state_q, state_d;
  logic [SET_W-1:0]               settle_q, settle_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [NOUT-1:0][TT_W-1:0]      table_q, table_d;
  logic [NOUT-1:0][CNT_W-1:0]     zeros_q, zeros_d;

  logic             vec_load, vec_step, vec_park, vec_last;
  logic [IDX_W-1:0] vec_idx;

  pos_vec_gen u_vec_gen (
    .clk   (clk),
    .reset (reset),
    .load  (vec_load),
    .mode3 (mode3),
    .step  (vec_step),
    .park  (vec_park),
    .idx   (vec_idx),
    .last  (vec_last),
    .x     (x),
    .y     (y),
    .w     (w),
    .z     (z)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    table_d  = table_q;
    zeros_d  = zeros_q;
    vec_load = 1'b0;
    vec_step = 1'b0;
    vec_park = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LD;
          busy_d   = 1'b1;
          table_d  = '0;
          zeros_d  = '0;
          vec_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q != '0) settle_d = settle_q - SET_W'(1);
        else                state_d  = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // Only a clean 0 counts as a maxterm; unknown samples are stored but not counted.
        for (int k = 0; k < NOUT; k++) begin
          table_d[k][vec_idx] = s[k];
          if (s[k] == 1'b0) zeros_d[k] = zeros_q[k] + CNT_W'(1);
        end
        if (vec_last) begin
          state_d = ST_DONE;
        end else begin
          vec_step = 1'b1;
          settle_d = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        vec_park = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= '0;
      zeros_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      table_q  <= table_d;
      zeros_q  <= zeros_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    rd_table = '0;
    rd_zeros = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (rd_sel == 3'(k)) begin
        rd_table = table_q[k];
        rd_zeros = zeros_q[k];
      end
    end
  end

endmodule
